// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter and its round-robin picker.
// Latency: n/a (types, defaults and a helper function only).
// Backpressure: n/a.
package cdb_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;

    // One CDB beat at the default widths, as seen by every listener.
    typedef struct packed {
        logic                  valid;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } cdb_bus_t;

    localparam logic [TAG_W_DEF-1:0] TAG_NONE = '0;

    // Round-robin pointer width; a single requester still gets one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of i_req scanning from i_ptr upward, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies o_grant with its own load enable.
//
// Ports:
//   i_req   request vector, bit i = requester i
//   i_ptr   highest-priority requester index this cycle (must be < N)
//   o_grant one-hot winner, all zero when i_req == 0
//   o_idx   encoded winner index, zero when i_req == 0
//   o_any   at least one request present
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        // Scan from the farthest offset back to the pointer so the candidate
        // closest to i_ptr is the last (and therefore winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_grant                          = '0;
                o_grant[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                            = PW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among FU results, winner registered onto the common data bus.
// Latency: granted at edge k, visible on cdbValid/cdbTag/cdbData during cycle k+1.
// Backpressure: cdbReady=0 with a valid beat held stalls the bus and withholds all grants.
//
// Ports:
//   clk, RST               clock; synchronous active-high reset
//   req/reqData/reqTag     per-FU request, result and RS tag (slice i = FU i)
//   grant                  combinational one-hot grant, result taken at this edge
//   cdbReady               listeners accept a new broadcast this cycle
//   cdbValid/cdbTag/cdbData registered broadcast
//   perfGrantCnt/perfStallCnt  saturating counters, present only when CDB_PERF_CNT_EN is defined
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] reqData,
    input  logic [N_REQ*TAG_W-1:0]  reqTag,
    output logic [N_REQ-1:0]        grant,
    input  logic                    cdbReady,
    output logic                    cdbValid,
    output logic [TAG_W-1:0]        cdbTag,
    output logic [DATA_W-1:0]       cdbData
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [N_REQ*16-1:0]     perfGrantCnt,
    output logic [15:0]             perfStallCnt
`endif
);

    localparam int PW = ptr_w(N_REQ);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic [PW-1:0]     r_rr_ptr;

    logic              w_load_en;
    logic [N_REQ-1:0]  w_pick;
    logic [PW-1:0]     w_idx;
    logic              w_any;
    logic              w_take;
    logic [PW-1:0]     w_next_ptr;

    rr_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_picker (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Output register may refill when empty or drained this cycle.
    assign w_load_en = !r_valid || cdbReady;
    // Reset suppresses grants so no FU believes its result was consumed.
    assign w_take    = !RST && w_load_en && w_any;
    assign grant     = w_take ? w_pick : '0;

    assign w_next_ptr = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_valid  <= 1'b1;
                r_tag    <= reqTag[int'(w_idx)*TAG_W +: TAG_W];
                r_data   <= reqData[int'(w_idx)*DATA_W +: DATA_W];
                r_rr_ptr <= w_next_ptr;
            end else begin
                // Drained with nobody waiting: bus goes idle, payload left as is.
                r_valid  <= 1'b0;
            end
        end
    end

    assign cdbValid = r_valid;
    assign cdbTag   = r_tag;
    assign cdbData  = r_data;

`ifdef CDB_PERF_CNT_EN
    logic [15:0] r_grant_cnt [N_REQ];
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && r_grant_cnt[i] != 16'hFFFF) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
            if (|req && !(|grant) && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        perfGrantCnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            perfGrantCnt[i*16 +: 16] = r_grant_cnt[i];
        end
    end

    assign perfStallCnt = r_stall_cnt;
`endif

endmodule
